// File: rtl/clint_ctrl_pkg.sv
// Shared constants, state encoding and mstatus helpers for the core-local
// interrupt controller.
package clint_ctrl_pkg;

  // CSR addresses on the clint write port
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  // Exact-match encodings of the system instructions handled here
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MCAUSE,
    S_MSTATUS,
    S_MRET,
    S_JUMP
  } clint_state_e;

  // Trap entry: stash MIE into MPIE and disable interrupts
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception controller. Accepts ECALL/EBREAK/MRET and
// level interrupts, stalls the pipeline while it writes mepc/mcause/mstatus
// through the CSR file's clint port, then pulses a redirect to mtvec or mepc.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3,
  parameter logic [31:0] INT_CAUSE    = 32'h8000_0007
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_started_i,
  input  logic        hold_flag_i,
  input  logic        int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cause_q, cause_d;
  logic [31:0]  tgt_q, tgt_d;

  logic is_ecall, is_ebreak, is_mret, async_req;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  // A busy divider defers the interrupt; the level is re-sampled next idle cycle
  assign async_req = int_flag_i & global_int_en_i & ~div_started_i;

  // State and latched trap context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

  // Event acceptance, CSR write sequencing and redirect generation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    tgt_d        = tgt_q;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!hold_flag_i) begin
          if (is_ecall || is_ebreak) begin
            pc_d        = inst_addr_i;
            cause_d     = is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
            state_d     = S_MEPC;
            hold_flag_o = 1'b1;
          end else if (is_mret) begin
            state_d     = S_MRET;
            hold_flag_o = 1'b1;
          end else if (async_req) begin
            // A taken branch in EX means its target is the next PC to resume at
            pc_d        = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_d     = INT_CAUSE;
            state_d     = S_MEPC;
            hold_flag_o = 1'b1;
          end
        end
      end

      S_MEPC: begin
        we_o        = 1'b1;
        waddr_o     = {20'd0, CSR_MEPC};
        data_o      = pc_q;
        hold_flag_o = 1'b1;
        state_d     = S_MCAUSE;
      end

      S_MCAUSE: begin
        we_o        = 1'b1;
        waddr_o     = {20'd0, CSR_MCAUSE};
        data_o      = cause_q;
        hold_flag_o = 1'b1;
        state_d     = S_MSTATUS;
      end

      S_MSTATUS: begin
        we_o        = 1'b1;
        waddr_o     = {20'd0, CSR_MSTATUS};
        data_o      = mstatus_on_trap(csr_mstatus_i);
        hold_flag_o = 1'b1;
        tgt_d       = csr_mtvec_i;
        state_d     = S_JUMP;
      end

      S_MRET: begin
        we_o        = 1'b1;
        waddr_o     = {20'd0, CSR_MSTATUS};
        data_o      = mstatus_on_mret(csr_mstatus_i);
        hold_flag_o = 1'b1;
        tgt_d       = csr_mepc_i;
        state_d     = S_JUMP;
      end

      S_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = tgt_q;
        hold_flag_o  = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Randomized bench for clint_ctrl with a transaction-level reference model
// and a small behavioural CSR file closing the mstatus/mepc/mtvec loop.
module tb_clint_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_started_i, hold_flag_i, int_flag_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  // Behavioural CSR file contents seen by the DUT
  logic [31:0] m_mstatus, m_mepc, m_mtvec;
  assign csr_mstatus_i   = m_mstatus;
  assign csr_mepc_i      = m_mepc;
  assign csr_mtvec_i     = m_mtvec;
  assign global_int_en_i = m_mstatus[3];

  clint_ctrl #(
    .ECALL_CAUSE (32'd11),
    .EBREAK_CAUSE(32'd3),
    .INT_CAUSE   (32'h8000_0007)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .inst_i         (inst_i),
    .inst_addr_i    (inst_addr_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .div_started_i  (div_started_i),
    .hold_flag_i    (hold_flag_i),
    .int_flag_i     (int_flag_i),
    .global_int_en_i(global_int_en_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .data_o         (data_o),
    .hold_flag_o    (hold_flag_o),
    .int_assert_o   (int_assert_o),
    .int_addr_o     (int_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: pending steps of the current transaction
  localparam int P_MEPC = 1, P_MCAUSE = 2, P_MSTAT = 3, P_MRET = 4, P_JUMP = 5;
  int          pend[$];
  logic [31:0] r_pc, r_cause, r_tgt;

  task automatic check_all(input logic [31:0] e_we, e_addr, e_data, e_hold, e_ia, e_iaddr);
    check("we",       {31'd0, we_o},         e_we);
    check("waddr",    waddr_o,               e_addr);
    check("data",     data_o,                e_data);
    check("hold",     {31'd0, hold_flag_o},  e_hold);
    check("assert",   {31'd0, int_assert_o}, e_ia);
    check("int_addr", int_addr_o,            e_iaddr);
  endtask

  // One clock: called at a negedge with inputs already applied
  task automatic step();
    logic [31:0] e_we, e_addr, e_data, e_hold, e_ia, e_iaddr;
    int s;
    #1;
    e_we = 0; e_addr = 0; e_data = 0; e_hold = 0; e_ia = 0; e_iaddr = 0;
    if (pend.size() == 0) begin
      if (!hold_flag_i) begin
        if (inst_i == 32'h0000_0073 || inst_i == 32'h0010_0073) begin
          r_pc    = inst_addr_i;
          r_cause = (inst_i == 32'h0000_0073) ? 32'd11 : 32'd3;
          pend    = '{P_MEPC, P_MCAUSE, P_MSTAT, P_JUMP};
          e_hold  = 1;
        end else if (inst_i == 32'h3020_0073) begin
          pend   = '{P_MRET, P_JUMP};
          e_hold = 1;
        end else if (int_flag_i && m_mstatus[3] && !div_started_i) begin
          r_pc    = jump_flag_i ? jump_addr_i : inst_addr_i;
          r_cause = 32'h8000_0007;
          pend    = '{P_MEPC, P_MCAUSE, P_MSTAT, P_JUMP};
          e_hold  = 1;
        end
      end
    end else begin
      s      = pend.pop_front();
      e_hold = 1;
      case (s)
        P_MEPC:   begin e_we = 1; e_addr = 32'h341; e_data = r_pc; end
        P_MCAUSE: begin e_we = 1; e_addr = 32'h342; e_data = r_cause; end
        P_MSTAT: begin
          e_we   = 1; e_addr = 32'h300;
          e_data = (m_mstatus & ~32'h88) | (m_mstatus[3] ? 32'h80 : 32'h0);
          r_tgt  = m_mtvec;
        end
        P_MRET: begin
          e_we   = 1; e_addr = 32'h300;
          e_data = (m_mstatus & ~32'h8) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
          r_tgt  = m_mepc;
        end
        default: begin e_ia = 1; e_iaddr = r_tgt; end
      endcase
    end
    check_all(e_we, e_addr, e_data, e_hold, e_ia, e_iaddr);
    @(posedge clk_i);
    #1;
    // CSR file absorbs the write the model expected
    if (e_we == 1) begin
      if (e_addr == 32'h300) m_mstatus = e_data;
      else if (e_addr == 32'h341) m_mepc = e_data;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    inst_i = 32'h0000_0013; inst_addr_i = 32'h0; jump_flag_i = 0; jump_addr_i = 32'h0;
    div_started_i = 0; hold_flag_i = 0; int_flag_i = 0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    m_mstatus = 32'h0; m_mepc = 32'h0; m_mtvec = 32'h0;
    #1;
    check_all(0, 0, 0, 0, 0, 0);
    @(negedge clk_i); @(negedge clk_i);
    // Release with a pending interrupt but MIE=0: nothing happens
    int_flag_i = 1;
    rst_ni = 1'b1;
    run_idle(3);

    // ECALL at 0x100, mstatus=0x8, mtvec=0x400
    m_mstatus = 32'h8; m_mtvec = 32'h400; int_flag_i = 0;
    inst_i = 32'h0000_0073; inst_addr_i = 32'h100;
    step();
    idle_inputs();
    run_idle(6);

    // Interrupt while EX takes a jump to 0x200
    m_mstatus = 32'h8; int_flag_i = 1; jump_flag_i = 1; jump_addr_i = 32'h200;
    inst_addr_i = 32'h180;
    step();
    idle_inputs();
    run_idle(5);

    // MRET with mstatus=0x80, mepc=0x104
    m_mstatus = 32'h80; m_mepc = 32'h104; inst_i = 32'h3020_0073;
    step();
    idle_inputs();
    run_idle(3);

    // Interrupt deferred by divider for 5 cycles, then taken
    m_mstatus = 32'h8; int_flag_i = 1; div_started_i = 1; inst_addr_i = 32'h300;
    run_idle(5);
    div_started_i = 0;
    step();
    int_flag_i = 0;
    run_idle(5);

    // ECALL and interrupt together: ECALL wins; level not taken while MIE=0
    m_mstatus = 32'h8; int_flag_i = 1; inst_i = 32'h0000_0073; inst_addr_i = 32'h500;
    step();
    inst_i = 32'h0000_0013;
    run_idle(8);
    m_mstatus = m_mstatus | 32'h8;
    run_idle(6);
    idle_inputs();
    run_idle(2);

    // Reset asserted while writing mcause
    m_mstatus = 32'h8; inst_i = 32'h0010_0073; inst_addr_i = 32'h600;
    step();
    idle_inputs();
    step();
    #1;
    rst_ni = 1'b0;
    #1;
    check_all(0, 0, 0, 0, 0, 0);
    pend.delete();
    m_mstatus = 32'h0;
    @(negedge clk_i); @(negedge clk_i);
    int_flag_i = 1;
    rst_ni = 1'b1;
    run_idle(6);

    // Randomized traffic through the closed CSR loop
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      if (pend.size() == 0) begin
        if ($urandom_range(0, 7) == 0) m_mstatus = $urandom();
        if ($urandom_range(0, 7) == 0) m_mepc = $urandom();
        m_mtvec = $urandom();
      end
      r = $urandom_range(0, 9);
      case (r)
        0:       inst_i = 32'h0000_0073;
        1:       inst_i = 32'h0010_0073;
        2:       inst_i = 32'h3020_0073;
        default: inst_i = $urandom();
      endcase
      inst_addr_i   = $urandom();
      jump_addr_i   = $urandom();
      jump_flag_i   = $urandom_range(0, 1) == 1;
      div_started_i = $urandom_range(0, 2) == 0;
      hold_flag_i   = $urandom_range(0, 4) == 0;
      int_flag_i    = $urandom_range(0, 2) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
